// File: rtl/pb_events_pkg.sv
// Shared definitions for the push-button gesture classifier: event codes,
// FSM state encodings and FIFO geometry.
package pb_events_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_SHORT  = 2'b01,
    EV_LONG   = 2'b10,
    EV_DOUBLE = 2'b11
  } ev_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_WAIT2   = 2'b10,
    ST_HELD    = 2'b11
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_events_if.sv
// Event drain handshake between the classifier and the MCS-51 peripheral side.
interface pb_events_if;
  logic       EV_valid;
  logic [1:0] EV_code;
  logic       EV_ready;

  modport master (output EV_valid, output EV_code, input EV_ready);
  modport slave  (input EV_valid, input EV_code, output EV_ready);
endinterface

// File: rtl/pb_evfifo.sv
// Synchronous 4x2-bit event FIFO; a push into a full FIFO without a same-cycle
// pop is dropped and reported on the one-cycle drop output.
module pb_evfifo
  import pb_events_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop_req,
  output logic       valid,
  output logic [1:0] head,
  output logic       full,
  output logic       drop
);

  logic [1:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                   (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign do_pop  = pop_req & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers empties
  // the FIFO and the head is masked while empty.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
  end

  assign valid = ~empty;
  assign head  = empty ? EV_NONE : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: rtl/pb_events.sv
// Push-button gesture classifier: turns debounced press/release strobes into
// SHORT / LONG / DOUBLE events queued for a valid/ready consumer.
module pb_events
  import pb_events_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int LONG_TICKS = 500,
  parameter int DBL_TICKS  = 250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PB_down,
  input  logic        PB_up,
  input  logic        OVF_clr,
  output logic        EV_ovf,
  pb_events_if.master ev
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(max_int(LONG_TICKS, DBL_TICKS) + 1);

  state_t        state, next_state;
  logic [PW-1:0] presc;
  logic [TW-1:0] ticks;
  logic          tick_now;
  logic          long_hit;
  logic          dbl_hit;
  logic          timer_clr;
  logic          emit;
  ev_code_t      emit_code;
  logic          down_v;
  logic          up_v;
  logic          fifo_full;
  logic          fifo_drop;

  // Simultaneous press and release strobes cancel each other out.
  assign down_v = PB_down & ~PB_up;
  assign up_v   = PB_up & ~PB_down;

  // Deadline N lands on the last prescaler step of tick N-1, i.e. exactly
  // TICK_DIV*N cycles after the clearing strobe.
  assign tick_now = (presc == PW'(TICK_DIV - 1));
  assign long_hit = tick_now && (ticks == TW'(LONG_TICKS - 1));
  assign dbl_hit  = tick_now && (ticks == TW'(DBL_TICKS - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge CLK) begin
    if (RST || timer_clr) begin
      presc <= '0;
      ticks <= '0;
    end else if (state == ST_PRESSED || state == ST_WAIT2) begin
      if (tick_now) begin
        presc <= '0;
        ticks <= ticks + TW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    next_state = state;
    timer_clr  = 1'b0;
    emit       = 1'b0;
    emit_code  = EV_NONE;
    unique case (state)
      ST_IDLE: begin
        if (down_v) begin
          next_state = ST_PRESSED;
          timer_clr  = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (long_hit) begin
          emit       = 1'b1;
          emit_code  = EV_LONG;
          next_state = up_v ? ST_IDLE : ST_HELD;
        end else if (up_v) begin
          next_state = ST_WAIT2;
          timer_clr  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (down_v) begin
          emit       = 1'b1;
          emit_code  = EV_DOUBLE;
          next_state = ST_HELD;
        end else if (dbl_hit) begin
          emit       = 1'b1;
          emit_code  = EV_SHORT;
          next_state = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (up_v) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  pb_evfifo u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (emit),
    .push_data (emit_code),
    .pop_req   (ev.EV_ready),
    .valid     (ev.EV_valid),
    .head      (ev.EV_code),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  // A drop sets the flag even when OVF_clr arrives in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST)            EV_ovf <= 1'b0;
    else if (fifo_drop) EV_ovf <= 1'b1;
    else if (OVF_clr)   EV_ovf <= 1'b0;
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
